// File: rtl/mask_serializer_ctrl_if.sv
// Row-source and serializer signals of the mask serializer controller.
// master is the controller side; slave is the row source plus serializer side.
interface mask_serializer_ctrl_if #(
  parameter int WIDTH = 640
) ();
  logic             row_valid;
  logic [WIDTH-1:0] row_data;
  logic             row_ready;
  logic [WIDTH-1:0] DIN;
  logic             load;
  logic             next;
  logic             done;
  logic [1:0]       ser_resolution;

  modport master (
    input  row_valid, row_data, done,
    output row_ready, DIN, load, next, ser_resolution
  );

  modport slave (
    output row_valid, row_data, done,
    input  row_ready, DIN, load, next, ser_resolution
  );
endinterface

// File: rtl/mask_serializer_ctrl.sv
// Frame controller: accepts rows one at a time, hands each one to the serializer,
// waits for its end-of-row, and counts rows until the frame for the latched resolution is done.
module mask_serializer_ctrl #(
  parameter int IP_CHANNEL_WIDTH = 640,
  parameter int stepSel0         = 16,
  parameter int stepSel1         = 32,
  parameter int stepSel2         = 54,
  parameter int ROWS_SEL0        = 16,
  parameter int ROWS_SEL1        = 32,
  parameter int ROWS_SEL2        = 54,
  parameter int TIMEOUT_SLACK    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  imageResolution,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] row_count,
  output logic [1:0]  err,
  mask_serializer_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_ROW, LOAD, GAP, SHIFT, ROW_END, ERROR
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  res_q;
  logic [15:0]                 shift_cnt;
  logic [15:0]                 shift_lim;
  logic [15:0]                 rows_lim;
  logic [IP_CHANNEL_WIDTH-1:0] din_q;
  logic                        valid_start;
  logic                        shift_timeout;
  logic                        last_row;

  // Resolution 3 is rejected at start, so it never reaches res_q.
  always_comb begin
    case (res_q)
      2'd0:    begin shift_lim = 16'(stepSel0 + TIMEOUT_SLACK); rows_lim = 16'(ROWS_SEL0); end
      2'd1:    begin shift_lim = 16'(stepSel1 + TIMEOUT_SLACK); rows_lim = 16'(ROWS_SEL1); end
      default: begin shift_lim = 16'(stepSel2 + TIMEOUT_SLACK); rows_lim = 16'(ROWS_SEL2); end
    endcase
  end

  assign valid_start   = start && (imageResolution != 2'd3);
  assign shift_timeout = (shift_cnt == shift_lim - 16'd1);
  assign last_row      = (row_count == rows_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE, ERROR: if (valid_start) state_d = WAIT_ROW;
      WAIT_ROW:    if (bus.row_valid) state_d = LOAD;
      LOAD:        state_d = GAP;
      GAP:         state_d = SHIFT;
      SHIFT: begin
        if (bus.done)          state_d = ROW_END;
        else if (shift_timeout) state_d = ERROR;
      end
      ROW_END:     state_d = last_row ? IDLE : WAIT_ROW;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is reset because a reset must clear all visible outputs.
      res_q     <= 2'd0;
      row_count <= 16'd0;
      err       <= 2'b00;
      shift_cnt <= 16'd0;
      din_q     <= '0;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (start && imageResolution == 2'd3) begin
            err[0] <= 1'b1;
          end else if (start) begin
            res_q     <= imageResolution;
            row_count <= 16'd0;
            err       <= 2'b00;
          end
        end
        WAIT_ROW: if (bus.row_valid) din_q <= bus.row_data;
        GAP:      shift_cnt <= 16'd0;
        SHIFT: begin
          shift_cnt <= shift_cnt + 16'd1;
          if (bus.done)           row_count <= row_count + 16'd1;
          else if (shift_timeout) err[1]    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // All strobes are decoded from the state register, so load and next can never overlap.
  assign bus.row_ready      = (state_q == WAIT_ROW);
  assign bus.load           = (state_q == LOAD);
  assign bus.next           = (state_q == SHIFT);
  assign bus.DIN            = din_q;
  assign bus.ser_resolution = res_q;
  assign busy               = (state_q != IDLE) && (state_q != ERROR);
  assign frame_done         = (state_q == ROW_END) && last_row;

endmodule

// File: tb/tb_mask_serializer_ctrl.sv
// Scenario bench for mask_serializer_ctrl: a serializer model answers next with done,
// and a row scoreboard checks every loaded DIN against the rows the source handed over.
module tb_mask_serializer_ctrl;
  localparam int W     = 640;
  localparam int BOUND = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  imageResolution = 2'd0;
  logic        busy, frame_done;
  logic [15:0] row_count;
  logic [1:0]  err;

  int checks = 0, failures = 0;
  int load_cnt = 0, fd_cnt = 0, next_cnt = 0;
  int model_n = 16;
  int mcnt = 0;
  logic done_en = 1'b1, done_inject = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  mask_serializer_ctrl_if #(.WIDTH(W)) bus ();

  mask_serializer_ctrl #(.IP_CHANNEL_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imageResolution(imageResolution),
    .busy(busy), .frame_done(frame_done), .row_count(row_count), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  // Serializer model: counts next cycles since the last load, raises done on the model_n-th.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mcnt <= 0;
    else if (bus.load) mcnt <= 0;
    else if (bus.next) mcnt <= mcnt + 1;
  end
  assign bus.done = (done_en && bus.next && (mcnt == model_n - 1)) || done_inject;

  initial begin
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
  end

  // Scoreboard side: every load must present the oldest row handed over.
  always @(negedge clk) begin
    if (bus.load) begin
      load_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL din_scoreboard: load seen with no row outstanding");
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.DIN !== mon_exp) begin
          failures++; $display("FAIL din_scoreboard: got %h want %h", bus.DIN, mon_exp);
        end
      end
      checks++;
      if (bus.next !== 1'b0) begin
        failures++; $display("FAIL load_next_overlap: next=%b want 0 while load=1", bus.next);
      end
    end
    if (bus.next === 1'b1) next_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic do_start(input logic [1:0] res);
    @(negedge clk); start = 1'b1; imageResolution = res;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy !== 1'b0 && t < BOUND) begin @(negedge clk); t++; end
    checks++;
    if (t >= BOUND) begin
      failures++; $display("FAIL %s_idle_wait: busy=%b after %0d cycles want 0", name, busy, t);
    end
  endtask

  // Hands n rows over; with stall>0 row_valid is held low for stall cycles once ready is seen.
  task automatic run_source(input int n, input int stall);
    logic [W-1:0] d;
    int t;
    for (int i = 0; i < n; i++) begin
      d = rand_row();
      if (stall > 0) begin
        bus.row_valid = 1'b0;
        t = 0;
        while (bus.row_ready !== 1'b1 && t < BOUND) begin @(negedge clk); t++; end
        for (int s = 0; s < stall; s++) begin
          checks++;
          if (bus.row_ready !== 1'b1 || bus.load !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: row_ready=%b load=%b want 1/0", bus.row_ready, bus.load);
          end
          @(negedge clk);
        end
      end
      bus.row_valid = 1'b1;
      bus.row_data  = d;
      t = 0;
      while (bus.row_ready !== 1'b1 && t < BOUND) begin @(negedge clk); t++; end
      checks++;
      if (t >= BOUND) begin
        failures++; $display("FAIL row_ready_wait: row_ready=%b after %0d cycles want 1", bus.row_ready, t);
        break;
      end
      exp_q.push_back(d);
      @(negedge clk);
    end
    bus.row_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, frame_done, row_count, err} !== 20'd0) begin
      failures++; $display("FAIL reset_status: busy=%b fd=%b rows=%0d err=%b want all 0", busy, frame_done, row_count, err);
    end
    checks++;
    if ({bus.load, bus.next, bus.row_ready, bus.ser_resolution} !== 5'd0) begin
      failures++; $display("FAIL reset_strobes: load=%b next=%b ready=%b res=%0d want all 0", bus.load, bus.next, bus.row_ready, bus.ser_resolution);
    end
    checks++;
    if (bus.DIN !== '0) begin failures++; $display("FAIL reset_din: got %h want 0", bus.DIN); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.row_ready !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b ready=%b want 0/0", busy, bus.row_ready);
    end
  endtask

  task automatic test_res1_stream();
    int l0 = load_cnt, f0 = fd_cnt, n0 = next_cnt;
    model_n = 32; done_en = 1'b1;
    do_start(2'd1);
    checks++;
    if (busy !== 1'b1 || bus.ser_resolution !== 2'd1) begin
      failures++; $display("FAIL res1_start: busy=%b res=%0d want 1/1", busy, bus.ser_resolution);
    end
    run_source(32, 0);
    wait_idle("res1");
    checks++;
    if (load_cnt - l0 != 32) begin failures++; $display("FAIL res1_loads: got %0d want 32", load_cnt - l0); end
    checks++;
    if (fd_cnt - f0 != 1) begin failures++; $display("FAIL res1_frame_done: got %0d want 1", fd_cnt - f0); end
    checks++;
    if (row_count !== 16'd32 || err !== 2'b00) begin
      failures++; $display("FAIL res1_final: rows=%0d err=%b want 32/00", row_count, err);
    end
    checks++;
    if (next_cnt - n0 != 32 * 32) begin failures++; $display("FAIL res1_next_cycles: got %0d want %0d", next_cnt - n0, 32 * 32); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL res1_leftover_rows: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_res0_stall();
    int l0 = load_cnt, f0 = fd_cnt;
    model_n = 16;
    do_start(2'd0);
    run_source(16, 5);
    wait_idle("res0_stall");
    checks++;
    if (load_cnt - l0 != 16) begin failures++; $display("FAIL stall_loads: got %0d want 16", load_cnt - l0); end
    checks++;
    if (fd_cnt - f0 != 1) begin failures++; $display("FAIL stall_frame_done: got %0d want 1", fd_cnt - f0); end
    checks++;
    if (row_count !== 16'd16) begin failures++; $display("FAIL stall_rows: got %0d want 16", row_count); end
  endtask

  task automatic test_bad_res();
    int l0 = load_cnt, f0;
    do_start(2'd3);
    checks++;
    if (err !== 2'b01 || busy !== 1'b0) begin
      failures++; $display("FAIL bad_res_err: err=%b busy=%b want 01/0", err, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (load_cnt != l0 || busy !== 1'b0) begin
      failures++; $display("FAIL bad_res_idle: loads=%0d busy=%b want 0/0", load_cnt - l0, busy);
    end
    model_n = 54;
    l0 = load_cnt; f0 = fd_cnt;
    do_start(2'd2);
    checks++;
    if (err !== 2'b00 || busy !== 1'b1) begin
      failures++; $display("FAIL res2_start: err=%b busy=%b want 00/1", err, busy);
    end
    run_source(54, 0);
    wait_idle("res2");
    checks++;
    if (load_cnt - l0 != 54 || fd_cnt - f0 != 1 || row_count !== 16'd54) begin
      failures++; $display("FAIL res2_frame: loads=%0d fd=%0d rows=%0d want 54/1/54", load_cnt - l0, fd_cnt - f0, row_count);
    end
  endtask

  task automatic test_timeout();
    int n0, f0 = fd_cnt, l0;
    model_n = 54; done_en = 1'b0;
    do_start(2'd2);
    n0 = next_cnt;
    run_source(1, 0);
    wait_idle("timeout");
    checks++;
    if (next_cnt - n0 != 58) begin failures++; $display("FAIL timeout_next_cycles: got %0d want 58", next_cnt - n0); end
    checks++;
    if (err !== 2'b10 || busy !== 1'b0 || row_count !== 16'd0) begin
      failures++; $display("FAIL timeout_status: err=%b busy=%b rows=%0d want 10/0/0", err, busy, row_count);
    end
    checks++;
    if (fd_cnt != f0) begin failures++; $display("FAIL timeout_frame_done: got %0d want 0", fd_cnt - f0); end
    l0 = load_cnt;
    bus.row_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.row_ready !== 1'b0 || load_cnt != l0 || bus.next !== 1'b0) begin
      failures++; $display("FAIL error_hold: ready=%b loads=%0d next=%b want 0/0/0", bus.row_ready, load_cnt - l0, bus.next);
    end
    bus.row_valid = 1'b0;
    done_en = 1'b1; model_n = 32;
    do_start(2'd1);
    checks++;
    if (busy !== 1'b1 || err !== 2'b00) begin
      failures++; $display("FAIL error_restart: busy=%b err=%b want 1/00", busy, err);
    end
  endtask

  // Continues the frame started from ERROR: aborts it during SHIFT of row 3.
  task automatic test_reset_mid();
    int t = 0, f0 = fd_cnt;
    run_source(3, 0);
    while (bus.next !== 1'b1 && t < BOUND) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    checks++;
    if (row_count !== 16'd2 || bus.next !== 1'b1) begin
      failures++; $display("FAIL mid_shift_row3: rows=%0d next=%b want 2/1", row_count, bus.next);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, row_count, err, bus.load, bus.next, bus.row_ready, bus.ser_resolution} !== 25'd0) begin
      failures++; $display("FAIL async_reset_outputs: busy=%b rows=%0d next=%b res=%0d want all 0", busy, row_count, bus.next, bus.ser_resolution);
    end
    checks++;
    if (bus.DIN !== '0) begin failures++; $display("FAIL async_reset_din: got %h want 0", bus.DIN); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (fd_cnt != f0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_no_frame_done: fd=%0d busy=%b want 0/0", fd_cnt - f0, busy);
    end
    do_start(2'd1);
    run_source(32, 0);
    wait_idle("after_reset");
    checks++;
    if (fd_cnt - f0 != 1 || row_count !== 16'd32 || err !== 2'b00) begin
      failures++; $display("FAIL after_reset_frame: fd=%0d rows=%0d err=%b want 1/32/00", fd_cnt - f0, row_count, err);
    end
  endtask

  task automatic test_ignored();
    int l0 = load_cnt, f0 = fd_cnt, n0;
    model_n = 16;
    do_start(2'd0);
    n0 = next_cnt;
    fork
      run_source(16, 0);
      begin
        int t = 0, rc;
        while (row_count !== 16'd4 && t < BOUND) begin @(negedge clk); t++; end
        start = 1'b1; imageResolution = 2'd2; rc = row_count;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus.ser_resolution !== 2'd0 || row_count < rc || busy !== 1'b1) begin
          failures++; $display("FAIL start_mid_frame: res=%0d rows=%0d busy=%b want 0/>=%0d/1", bus.ser_resolution, row_count, busy, rc);
        end
        t = 0;
        while (bus.load !== 1'b1 && t < BOUND) begin @(negedge clk); t++; end
        @(negedge clk);
        rc = row_count;
        checks++;
        if (bus.load !== 1'b0 || bus.next !== 1'b0) begin
          failures++; $display("FAIL gap_strobes: load=%b next=%b want 0/0", bus.load, bus.next);
        end
        done_inject = 1'b1;
        @(negedge clk);
        done_inject = 1'b0;
        checks++;
        if (row_count !== 16'(rc) || bus.next !== 1'b1) begin
          failures++; $display("FAIL done_in_gap: rows=%0d next=%b want %0d/1", row_count, bus.next, rc);
        end
      end
    join
    wait_idle("ignored");
    checks++;
    if (load_cnt - l0 != 16 || fd_cnt - f0 != 1 || row_count !== 16'd16) begin
      failures++; $display("FAIL ignored_frame: loads=%0d fd=%0d rows=%0d want 16/1/16", load_cnt - l0, fd_cnt - f0, row_count);
    end
    checks++;
    if (next_cnt - n0 != 16 * 16 || err !== 2'b00) begin
      failures++; $display("FAIL ignored_next_cycles: next=%0d err=%b want %0d/00", next_cnt - n0, err, 16 * 16);
    end
  endtask

  initial begin
    test_reset();
    test_res1_stream();
    test_res0_stall();
    test_bad_res();
    test_timeout();
    test_reset_mid();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
